i2s_voice_sched: RTL and testbench

- Per-audio-frame scheduler that feeds the I2S transmitter's 24-bit left/right sample inputs.
- Once per LR frame it polls NUM_VOICES synth voices in fixed order over one shared request/valid sample bus.
- It sums their stereo samples with saturation, then publishes the mix atomically on outLeft/outRight.
- Sits between the synth voice generators and the I2S serialiser, all in the 25 MHz sclk domain.

---
 rtl/i2s_voice_sched.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_voice_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_voice_sched.sv
// Per-frame voice scheduler: on each synchronised lrclk rise, polls NUM_VOICES
// voices over a shared request/valid bus, sums their stereo samples with
// saturation and publishes the mix atomically on outLeft/outRight.
// Ports:
//   sclk, rst_n          clock, async active-low reset
//   lrclk                I2S frame clock (async, synchronised here)
//   mute                 per-voice mute, muted voices are skipped
//   voice_sel/sample_req voice index and request strobe to the voices
//   sample_valid/_left/_right  response from the selected voice
//   outLeft/outRight     published mix, frame_strobe pulses on update
//   busy                 polling sequence in progress
//   underrun_cnt         saturating count of voice timeouts
//   overrun              sticky, frame trigger arrived while busy
module i2s_voice_sched #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned LG        = $clog2(NUM_VOICES),
  localparam int unsigned SEL_W     = (LG == 0) ? 1 : LG
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  lrclk,
  input  logic [NUM_VOICES-1:0] mute,
  output logic [SEL_W-1:0]      voice_sel,
  output logic                  sample_req,
  input  logic                  sample_valid,
  input  logic [WIDTH-1:0]      sample_left,
  input  logic [WIDTH-1:0]      sample_right,
  output logic [WIDTH-1:0]      outLeft,
  output logic [WIDTH-1:0]      outRight,
  output logic                  frame_strobe,
  output logic                  busy,
  output logic [7:0]            underrun_cnt,
  output logic                  overrun
);

  localparam int unsigned ACC_W = WIDTH + LG;
  localparam int unsigned TMO_W = ($clog2(TIMEOUT) == 0) ? 1 : $clog2(TIMEOUT);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VOICES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_POLL    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  logic [1:0]       r_state, w_nxt_state;
  logic [SEL_W-1:0] r_idx, w_nxt_idx;
  logic [ACC_W-1:0] r_acc_l, r_acc_r, w_nxt_acc_l, w_nxt_acc_r;
  logic [TMO_W-1:0] r_tmo, w_nxt_tmo;
  logic             r_req, w_nxt_req;
  logic             r_busy, w_nxt_busy;
  logic             r_strobe, w_nxt_strobe;
  logic [WIDTH-1:0] r_out_l, r_out_r, w_nxt_out_l, w_nxt_out_r;
  logic [7:0]       r_und, w_nxt_und;
  logic             r_ovr, w_nxt_ovr;
  logic             r_lr_s1, r_lr_s2, r_lr_d;
  logic             w_trig;
  logic             w_adv;

  // Clamp a wide accumulator into the signed WIDTH range.
  function automatic logic [WIDTH-1:0] sat(input logic [ACC_W-1:0] a);
    logic [ACC_W-WIDTH:0] hi;
    hi = a[ACC_W-1:WIDTH-1];
    if ((&hi) || !(|hi)) return a[WIDTH-1:0];
    else if (a[ACC_W-1]) return {1'b1, {(WIDTH-1){1'b0}}};
    else return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign w_trig = r_lr_s2 & ~r_lr_d;

  // Next-state and datapath.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_nxt_acc_l  = r_acc_l;
    w_nxt_acc_r  = r_acc_r;
    w_nxt_tmo    = r_tmo;
    w_nxt_req    = 1'b0;
    w_nxt_busy   = r_busy;
    w_nxt_strobe = 1'b0;
    w_nxt_out_l  = r_out_l;
    w_nxt_out_r  = r_out_r;
    w_nxt_und    = r_und;
    w_nxt_ovr    = r_ovr;
    w_adv        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_nxt_state = S_POLL;
          w_nxt_idx   = '0;
          w_nxt_acc_l = '0;
          w_nxt_acc_r = '0;
          w_nxt_busy  = 1'b1;
        end
      end
      S_POLL: begin
        // r_req was precomputed from mute on entry, so request and skip agree.
        if (r_req) begin
          w_nxt_state = S_WAIT;
          w_nxt_tmo   = '0;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_WAIT: begin
        if (sample_valid) begin
          w_nxt_acc_l = r_acc_l + ACC_W'($signed(sample_left));
          w_nxt_acc_r = r_acc_r + ACC_W'($signed(sample_right));
          w_adv       = 1'b1;
        end else if (r_tmo == TMO_LAST) begin
          if (r_und != 8'hFF) w_nxt_und = r_und + 8'd1;
          w_adv = 1'b1;
        end else begin
          w_nxt_tmo = r_tmo + TMO_W'(1);
        end
      end
      default: begin
        w_nxt_out_l  = sat(r_acc_l);
        w_nxt_out_r  = sat(r_acc_r);
        w_nxt_strobe = 1'b1;
        w_nxt_busy   = 1'b0;
        w_nxt_state  = S_IDLE;
      end
    endcase

    if (w_adv) begin
      if (r_idx == LAST_IDX) begin
        w_nxt_state = S_PUBLISH;
      end else begin
        w_nxt_idx   = r_idx + SEL_W'(1);
        w_nxt_state = S_POLL;
      end
    end

    // A trigger mid-sequence aborts it and restarts from voice 0.
    if (w_trig && (r_state != S_IDLE)) begin
      w_nxt_ovr    = 1'b1;
      w_nxt_state  = S_POLL;
      w_nxt_idx    = '0;
      w_nxt_acc_l  = '0;
      w_nxt_acc_r  = '0;
      w_nxt_busy   = 1'b1;
      w_nxt_strobe = 1'b0;
      w_nxt_out_l  = r_out_l;
      w_nxt_out_r  = r_out_r;
    end

    // Request is visible from the POLL cycle of an unmuted voice through WAIT.
    w_nxt_req = (w_nxt_state == S_WAIT) ||
                ((w_nxt_state == S_POLL) && !mute[w_nxt_idx]);
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_tmo    <= '0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_out_l  <= '0;
      r_out_r  <= '0;
      r_und    <= 8'd0;
      r_ovr    <= 1'b0;
      r_lr_s1  <= 1'b0;
      r_lr_s2  <= 1'b0;
      r_lr_d   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_idx    <= w_nxt_idx;
      r_acc_l  <= w_nxt_acc_l;
      r_acc_r  <= w_nxt_acc_r;
      r_tmo    <= w_nxt_tmo;
      r_req    <= w_nxt_req;
      r_busy   <= w_nxt_busy;
      r_strobe <= w_nxt_strobe;
      r_out_l  <= w_nxt_out_l;
      r_out_r  <= w_nxt_out_r;
      r_und    <= w_nxt_und;
      r_ovr    <= w_nxt_ovr;
      r_lr_s1  <= lrclk;
      r_lr_s2  <= r_lr_s1;
      r_lr_d   <= r_lr_s2;
    end
  end

  assign voice_sel    = r_idx;
  assign sample_req   = r_req;
  assign outLeft      = r_out_l;
  assign outRight     = r_out_r;
  assign frame_strobe = r_strobe;
  assign busy         = r_busy;
  assign underrun_cnt = r_und;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_i2s_voice_sched.sv
// Self-checking bench for i2s_voice_sched: directed and randomized frames
// checked against a frame-level model of sum, saturation, latency and timeouts.
module tb_i2s_voice_sched;

  localparam int NV = 4;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        lrclk;
  logic [3:0]  mute;
  logic [1:0]  voice_sel;
  logic        sample_req;
  logic        sample_valid;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic [23:0] outLeft;
  logic [23:0] outRight;
  logic        frame_strobe;
  logic        busy;
  logic [7:0]  underrun_cnt;
  logic        overrun;

  i2s_voice_sched #(.NUM_VOICES(4), .WIDTH(24), .TIMEOUT(64)) dut (
    .sclk(sclk), .rst_n(rst_n), .lrclk(lrclk), .mute(mute),
    .voice_sel(voice_sel), .sample_req(sample_req),
    .sample_valid(sample_valid), .sample_left(sample_left),
    .sample_right(sample_right), .outLeft(outLeft), .outRight(outRight),
    .frame_strobe(frame_strobe), .busy(busy),
    .underrun_cnt(underrun_cnt), .overrun(overrun)
  );

  always #20 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  // Voice behaviour: dly = cycles after the first request cycle to answer, -1 never.
  int          dly[NV];
  logic [23:0] sl[NV];
  logic [23:0] sr[NV];
  int          seen_cnt[NV];
  int          last_run[NV];
  int          run;
  logic        prev_req;
  logic [1:0]  prev_sel;

  // Expected frame results.
  logic [23:0] exp_l, exp_r, last_l, last_r;
  int          exp_lat;
  int          und_m;

  initial begin
    for (int v = 0; v < NV; v++) begin
      seen_cnt[v] = 0;
      last_run[v] = 0;
    end
    run = 0;
    prev_req = 1'b0;
    prev_sel = 2'd0;
  end

  // Voice responder; drives junk valid/data whenever no request is pending.
  always @(negedge sclk) begin
    if (prev_req && !(sample_req && voice_sel == prev_sel))
      last_run[prev_sel] = run + 1;
    if (sample_req) begin
      if (prev_req && voice_sel == prev_sel) run = run + 1;
      else run = 0;
      seen_cnt[voice_sel] = seen_cnt[voice_sel] + 1;
      if (dly[voice_sel] >= 0 && run == dly[voice_sel]) begin
        sample_valid = 1'b1;
        sample_left  = sl[voice_sel];
        sample_right = sr[voice_sel];
      end else begin
        sample_valid = 1'b0;
        sample_left  = 24'($urandom);
        sample_right = 24'($urandom);
      end
    end else begin
      run = 0;
      sample_valid = 1'($urandom_range(0, 1));
      sample_left  = 24'($urandom);
      sample_right = 24'($urandom);
    end
    prev_req = sample_req;
    prev_sel = voice_sel;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sat24(input longint s);
    if (s > 64'sd8388607) return 24'h7FFFFF;
    if (s < -64'sd8388608) return 24'h800000;
    return 24'(s);
  endfunction

  // Frame model: sum of answering unmuted voices, cycle count, timeouts.
  task automatic model();
    longint sum_l = 0, sum_r = 0;
    int lat = 1;
    int tmo = 0;
    for (int v = 0; v < NV; v++) begin
      if (mute[v]) begin
        lat += 1;
      end else if (dly[v] >= 1 && dly[v] <= 64) begin
        sum_l += longint'($signed(sl[v]));
        sum_r += longint'($signed(sr[v]));
        lat += 1 + dly[v];
      end else begin
        lat += 1 + 64;
        tmo++;
      end
    end
    exp_l = sat24(sum_l);
    exp_r = sat24(sum_r);
    exp_lat = lat;
    und_m = (und_m + tmo > 255) ? 255 : und_m + tmo;
  endtask

  task automatic run_frame(input string tag);
    int lat;
    bit ok;
    model();
    lrclk = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      if (busy) begin ok = 1'b1; break; end
    end
    chk({tag, "_busy_rise"}, 32'(ok), 32'd1);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      lat++;
      if (frame_strobe) begin ok = 1'b1; break; end
    end
    chk({tag, "_strobe_seen"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_outL"}, 32'(outLeft), 32'(exp_l));
    chk({tag, "_outR"}, 32'(outRight), 32'(exp_r));
    chk({tag, "_underrun"}, 32'(underrun_cnt), 32'(und_m));
    last_l = exp_l;
    last_r = exp_r;
    @(negedge sclk);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_strobe_1cyc"}, 32'(frame_strobe), 32'd0);
    lrclk = 1'b0;
    repeat (4) @(negedge sclk);
  endtask

  task automatic wait_sel_req(input logic [1:0] sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sclk);
      if (sample_req && voice_sel == sel) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    int s0[NV];
    int strobes;
    bit ok;

    rst_n = 1'b0;
    lrclk = 1'b0;
    mute  = 4'b0000;
    und_m = 0;
    last_l = 24'd0;
    last_r = 24'd0;
    for (int v = 0; v < NV; v++) begin
      dly[v] = 1; sl[v] = 24'd0; sr[v] = 24'd0;
    end
    repeat (3) @(negedge sclk);
    chk("rst_outL", 32'(outLeft), 32'd0);
    chk("rst_outR", 32'(outRight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(sample_req), 32'd0);
    chk("rst_sel", 32'(voice_sel), 32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_und", 32'(underrun_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge sclk);

    // Basic mix, each voice answers one cycle after its request.
    sl[0] = 24'd100; sl[1] = 24'd200; sl[2] = 24'(-50); sl[3] = 24'd7;
    for (int v = 0; v < NV; v++) sr[v] = 24'd1;
    run_frame("basic");

    // Positive and negative saturation.
    for (int v = 0; v < NV; v++) begin sl[v] = 24'h600000; sr[v] = 24'h0; end
    run_frame("sat_pos");
    for (int v = 0; v < NV; v++) sl[v] = 24'hA00000;
    run_frame("sat_neg");

    // Muted voices are never requested.
    mute = 4'b1010;
    sl[0] = 24'd10; sl[2] = 24'd20; sl[1] = 24'd999; sl[3] = 24'd999;
    for (int v = 0; v < NV; v++) s0[v] = seen_cnt[v];
    run_frame("mute");
    chk("mute_v1_req", 32'(seen_cnt[1] - s0[1]), 32'd0);
    chk("mute_v3_req", 32'(seen_cnt[3] - s0[3]), 32'd0);
    chk("mute_v0_req", 32'(seen_cnt[0] - s0[0] > 0), 32'd1);
    chk("mute_v2_req", 32'(seen_cnt[2] - s0[2] > 0), 32'd1);

    // All voices muted.
    mute = 4'b1111;
    run_frame("all_mute");
    mute = 4'b0000;

    // Voice 1 never answers: 1 request cycle in POLL plus 64 in WAIT.
    for (int v = 0; v < NV; v++) begin sl[v] = 24'd5; sr[v] = 24'd0; dly[v] = 1; end
    dly[1] = -1;
    run_frame("timeout");
    chk("timeout_req_run", 32'(last_run[1]), 32'd65);

    // Randomized frames, including valid on the last timeout cycle (64).
    for (int f = 0; f < 25; f++) begin
      mute = 4'($urandom);
      for (int v = 0; v < NV; v++) begin
        sl[v] = 24'($urandom);
        sr[v] = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 255)) : 24'($urandom);
        case ($urandom_range(0, 6))
          0: dly[v] = 1;
          1: dly[v] = 2;
          2: dly[v] = 3;
          3: dly[v] = 7;
          4: dly[v] = 64;
          5: dly[v] = 65;
          default: dly[v] = -1;
        endcase
      end
      run_frame("rand");
    end

    // Drive underrun counter into saturation.
    mute = 4'b0000;
    for (int v = 0; v < NV; v++) begin sl[v] = 24'd5; sr[v] = 24'd0; dly[v] = 1; end
    dly[1] = -1;
    for (int f = 0; f < 300; f++) run_frame("und_sat");
    chk("und_sat_255", 32'(underrun_cnt), 32'd255);

    // Trigger arriving during voice 3's wait.
    chk("ovr_before", 32'(overrun), 32'd0);
    for (int v = 0; v < NV; v++) begin sl[v] = 24'(v + 1); sr[v] = 24'(v); dly[v] = 1; end
    dly[3] = -1;
    lrclk = 1'b1;
    wait_sel_req(2'd3, ok);
    chk("ovr_reach_v3", 32'(ok), 32'd1);
    repeat (10) @(negedge sclk);
    lrclk = 1'b0;
    repeat (2) @(negedge sclk);
    lrclk = 1'b1;
    strobes = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      if (frame_strobe) strobes++;
      if (sample_req && voice_sel == 2'd0) begin ok = 1'b1; break; end
    end
    chk("ovr_restart_v0", 32'(ok), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_no_strobe", 32'(strobes), 32'd0);
    chk("ovr_hold_L", 32'(outLeft), 32'(last_l));
    chk("ovr_hold_R", 32'(outRight), 32'(last_r));
    chk("ovr_busy", 32'(busy), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      if (frame_strobe) begin ok = 1'b1; break; end
    end
    chk("ovr_finish", 32'(ok), 32'd1);
    chk("ovr_outL", 32'(outLeft), 32'd6);
    chk("ovr_outR", 32'(outRight), 32'd3);
    lrclk = 1'b0;
    repeat (4) @(negedge sclk);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during the wait on voice 2.
    for (int v = 0; v < NV; v++) dly[v] = 1;
    dly[2] = -1;
    lrclk = 1'b1;
    wait_sel_req(2'd2, ok);
    chk("rst_mid_reach_v2", 32'(ok), 32'd1);
    repeat (5) @(negedge sclk);
    lrclk = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outL", 32'(outLeft), 32'd0);
    chk("rst_mid_outR", 32'(outRight), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_req", 32'(sample_req), 32'd0);
    chk("rst_mid_sel", 32'(voice_sel), 32'd0);
    chk("rst_mid_und", 32'(underrun_cnt), 32'd0);
    chk("rst_mid_ovr", 32'(overrun), 32'd0);
    @(negedge sclk);
    rst_n = 1'b1;
    und_m = 0;
    repeat (4) @(negedge sclk);
    chk("rst_mid_no_strobe", 32'(frame_strobe), 32'd0);
    for (int v = 0; v < NV; v++) begin
      dly[v] = 1; sl[v] = 24'($urandom); sr[v] = 24'($urandom);
    end
    run_frame("post_rst");
    chk("post_rst_ovr", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
